// File: rtl/matrix_calc_pkg.sv
// matrix_calc_pkg: op codes, FSM states and shared helpers for the matrix compute engine
package matrix_calc_pkg;

    localparam int MAX_DIM = 5;

    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_SUB       = 4'd2;
    localparam logic [3:0] OP_SCALE     = 4'd3;
    localparam logic [3:0] OP_TRANSPOSE = 4'd4;
    localparam logic [3:0] OP_MUL       = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        EW_RD,
        EW_WR,
        MAC_RD,
        MAC_LAST,
        MAC_WR,
        DONE,
        ERR,
        WAIT_LOW
    } state_t;

    function automatic logic dim_in_range(input logic [2:0] d, input logic [2:0] max_d);
        return (d != 3'd0) && (d <= max_d);
    endfunction

endpackage

// File: rtl/matrix_index_gen.sv
// matrix_index_gen: row/col/k traversal counters and operand/result address generation
module matrix_index_gen #(
    parameter int MAX_DIM = 5,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              step,
    input  logic              k_inc,
    input  logic              transpose,
    input  logic              mul,
    input  logic [2:0]        rows,
    input  logic [2:0]        cols,
    input  logic [2:0]        n,
    output logic [2:0]        k,
    output logic              last_elem,
    output logic              last_k,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [2:0] i, j;

    function automatic logic [ADDR_W-1:0] addr(input logic [2:0] r, input logic [2:0] c);
        return ADDR_W'(int'(r) * MAX_DIM + int'(c));
    endfunction

    // row-major walk over the result; k restarts at every new element
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            i <= 3'd0;
            j <= 3'd0;
            k <= 3'd0;
        end else if (step) begin
            k <= 3'd0;
            if (j == cols - 3'd1) begin
                j <= 3'd0;
                i <= (i == rows - 3'd1) ? 3'd0 : i + 3'd1;
            end else begin
                j <= j + 3'd1;
            end
        end else if (k_inc) begin
            k <= k + 3'd1;
        end
    end

    // transpose reads A with row/col swapped; MUL walks A along a row and B down a column
    always_comb begin
        last_elem = (i == rows - 3'd1) && (j == cols - 3'd1);
        last_k    = (k == n - 3'd1);
        a_addr    = mul ? addr(i, k) : transpose ? addr(j, i) : addr(i, j);
        b_addr    = mul ? addr(k, j) : addr(i, j);
        wr_addr   = addr(i, j);
    end

endmodule

// File: rtl/matrix_compute_engine.sv
// matrix_compute_engine: element-wise and multiply matrix operations driven by a level start handshake
module matrix_compute_engine #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int MAX_DIM = matrix_calc_pkg::MAX_DIM,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_calc,
    input  logic [3:0]        op_type,
    input  logic [2:0]        a_rows,
    input  logic [2:0]        a_cols,
    input  logic [2:0]        b_rows,
    input  logic [2:0]        b_cols,
    input  logic [DATA_W-1:0] scalar,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RES_W-1:0]  wr_data,
    output logic [2:0]        res_rows,
    output logic [2:0]        res_cols,
    output logic              busy,
    output logic              calc_done,
    output logic              error
);

    import matrix_calc_pkg::*;

    localparam logic [2:0] MAXD  = 3'(MAX_DIM);
    localparam int         ACC_W = RES_W + 3;

    state_t              state, state_nx;
    logic                start_d;
    logic [3:0]          op;
    logic [2:0]          ar, ac, br, bc;
    logic [DATA_W-1:0]   sc;
    logic [ACC_W-1:0]    acc;
    logic                accept, dims_ok, a_ok, b_ok, is_mul, rd, wr;
    logic                last_elem, last_k;
    logic [2:0]          k;
    logic [ADDR_W-1:0]   ia, ib, iw;
    logic [RES_W-1:0]    ew_res;

    matrix_index_gen #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state == CHECK),
        .step      (wr),
        .k_inc     (state == MAC_RD),
        .transpose (op == OP_TRANSPOSE),
        .mul       (is_mul),
        .rows      (res_rows),
        .cols      (res_cols),
        .n         (ac),
        .k         (k),
        .last_elem (last_elem),
        .last_k    (last_k),
        .a_addr    (ia),
        .b_addr    (ib),
        .wr_addr   (iw)
    );

    // request decode, result shape and element-wise arithmetic from the latched request
    always_comb begin
        accept   = (state == IDLE) && start_calc && !start_d;
        is_mul   = (op == OP_MUL);
        a_ok     = dim_in_range(ar, MAXD) && dim_in_range(ac, MAXD);
        b_ok     = dim_in_range(br, MAXD) && dim_in_range(bc, MAXD);
        dims_ok  = (op == OP_ADD || op == OP_SUB) ? (a_ok && b_ok && ar == br && ac == bc) :
                   (op == OP_SCALE || op == OP_TRANSPOSE) ? a_ok :
                   is_mul ? (a_ok && b_ok && ac == br) : 1'b0;
        res_rows = (op == OP_TRANSPOSE) ? ac : ar;
        res_cols = (op == OP_TRANSPOSE) ? ar : is_mul ? bc : ac;
        ew_res   = (op == OP_ADD) ? RES_W'(a_data) + RES_W'(b_data) :
                   (op == OP_SUB) ? ((a_data >= b_data) ? RES_W'(a_data - b_data) : '0) :
                   (op == OP_SCALE) ? RES_W'(a_data) * RES_W'(sc) : RES_W'(a_data);
    end

    // outputs are decoded from the registered state and forced to zero outside their valid window
    always_comb begin
        rd        = (state == EW_RD) || (state == MAC_RD);
        wr        = (state == EW_WR) || (state == MAC_WR);
        busy      = (state != IDLE);
        calc_done = (state == DONE);
        error     = (state == ERR);
        wr_en     = wr;
        a_addr    = rd ? ia : '0;
        b_addr    = rd ? ib : '0;
        wr_addr   = wr ? iw : '0;
        wr_data   = (state == EW_WR) ? ew_res :
                    (state == MAC_WR) ? ((|acc[ACC_W-1:RES_W]) ? '1 : acc[RES_W-1:0]) : '0;
    end

    // next-state logic for the compute sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = accept ? CHECK : IDLE;
            CHECK:    state_nx = !dims_ok ? ERR : is_mul ? MAC_RD : EW_RD;
            EW_RD:    state_nx = EW_WR;
            EW_WR:    state_nx = last_elem ? DONE : EW_RD;
            MAC_RD:   state_nx = last_k ? MAC_LAST : MAC_RD;
            MAC_LAST: state_nx = MAC_WR;
            MAC_WR:   state_nx = last_elem ? DONE : MAC_RD;
            DONE:     state_nx = WAIT_LOW;
            ERR:      state_nx = WAIT_LOW;
            WAIT_LOW: state_nx = start_calc ? WAIT_LOW : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // state register and start edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_d <= 1'b0;
        end else begin
            state   <= state_nx;
            start_d <= start_calc;
        end
    end

    // request latch and MAC accumulator; the k=0 read cycle carries no data yet
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op  <= '0;
            ar  <= '0;
            ac  <= '0;
            br  <= '0;
            bc  <= '0;
            sc  <= '0;
            acc <= '0;
        end else begin
            if (accept) begin
                op <= op_type;
                ar <= a_rows;
                ac <= a_cols;
                br <= b_rows;
                bc <= b_cols;
                sc <= scalar;
            end
            if (state_nx == MAC_RD && state != MAC_RD)
                acc <= '0;
            else if ((state == MAC_RD && k != 3'd0) || state == MAC_LAST)
                acc <= acc + ACC_W'(a_data) * ACC_W'(b_data);
        end
    end

endmodule

// File: tb/tb_matrix_compute_engine.sv
// tb_matrix_compute_engine: scoreboard bench with a behavioural matrix model and randomized requests
module tb_matrix_compute_engine;

    import matrix_calc_pkg::*;

    typedef struct {
        int kind;
        int addr;
        int data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_calc = 1'b0;
    logic [3:0]  op_type = '0;
    logic [2:0]  a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
    logic [7:0]  scalar = '0;
    logic [4:0]  a_addr, b_addr, wr_addr;
    logic [7:0]  a_data, b_data;
    logic        wr_en, busy, calc_done, error;
    logic [15:0] wr_data;
    logic [2:0]  res_rows, res_cols;

    logic [7:0]  mem_a [32];
    logic [7:0]  mem_b [32];
    exp_t        q [$];
    int          errors = 0;
    int          checks = 0;
    exp_t        mon_e;
    int          mon_kind;

    matrix_compute_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_calc (start_calc),
        .op_type    (op_type),
        .a_rows     (a_rows),
        .a_cols     (a_cols),
        .b_rows     (b_rows),
        .b_cols     (b_cols),
        .scalar     (scalar),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .a_data     (a_data),
        .b_data     (b_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .res_rows   (res_rows),
        .res_cols   (res_cols),
        .busy       (busy),
        .calc_done  (calc_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // matrix store with one-cycle read latency
    always @(posedge clk) begin
        a_data <= mem_a[a_addr];
        b_data <= mem_b[b_addr];
    end

    // monitor: every write/done/error must match the head of the expected queue
    always @(negedge clk) begin
        if (wr_en || calc_done || error) begin
            mon_kind = wr_en ? 0 : calc_done ? 1 : 2;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard unexpected kind=%0d addr=%0d data=%0d", mon_kind, wr_addr, wr_data);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.kind != mon_kind || (mon_kind == 0 && (mon_e.addr != int'(wr_addr) || mon_e.data != int'(wr_data)))) begin
                    errors++;
                    $display("FAIL scoreboard got kind=%0d addr=%0d data=%0d expected kind=%0d addr=%0d data=%0d",
                             mon_kind, wr_addr, wr_data, mon_e.kind, mon_e.addr, mon_e.data);
                end
            end
        end else begin
            checks++;
            if (wr_addr != 5'd0 || wr_data != 16'd0) begin
                errors++;
                $display("FAIL idle_write_bus got addr=%0d data=%0d expected 0", wr_addr, wr_data);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_a_addr"}, int'(a_addr), 0);
        chk({tag, "_b_addr"}, int'(b_addr), 0);
        chk({tag, "_res_rows"}, int'(res_rows), 0);
        chk({tag, "_res_cols"}, int'(res_cols), 0);
        chk({tag, "_done"}, int'(calc_done), 0);
        chk({tag, "_error"}, int'(error), 0);
    endtask

    function automatic bit in_rng(input int d);
        return d >= 1 && d <= 5;
    endfunction

    function automatic int ea(input int r, input int c);
        return int'(mem_a[r * 5 + c]);
    endfunction

    function automatic int eb(input int r, input int c);
        return int'(mem_b[r * 5 + c]);
    endfunction

    // reference model: push the full expected response, then issue the request and track it to completion
    task automatic do_op(input int o, input int ar, input int ac, input int br, input int bc, input int s, input int hold);
        bit ok;
        int rr, rc, v, lat, exp_lat, cnt;
        bit got;
        ok = (o == 1 || o == 2) ? (in_rng(ar) && in_rng(ac) && ar == br && ac == bc) :
             (o == 3 || o == 4) ? (in_rng(ar) && in_rng(ac)) :
             (o == 8) ? (in_rng(ar) && in_rng(ac) && in_rng(br) && in_rng(bc) && ac == br) : 1'b0;
        rr = (o == 4) ? ac : ar;
        rc = (o == 4) ? ar : (o == 8) ? bc : ac;
        if (ok) begin
            for (int r = 0; r < rr; r++) begin
                for (int c = 0; c < rc; c++) begin
                    case (o)
                        1: v = ea(r, c) + eb(r, c);
                        2: v = (ea(r, c) > eb(r, c)) ? ea(r, c) - eb(r, c) : 0;
                        3: v = ea(r, c) * s;
                        4: v = ea(c, r);
                        default: begin
                            v = 0;
                            for (int x = 0; x < ac; x++) v += ea(r, x) * eb(x, c);
                            if (v > 65535) v = 65535;
                        end
                    endcase
                    q.push_back('{0, r * 5 + c, v});
                end
            end
            q.push_back('{1, 0, 0});
            exp_lat = 2 + rr * rc * ((o == 8) ? ac + 2 : 2);
        end else begin
            q.push_back('{2, 0, 0});
            exp_lat = 2;
        end
        @(negedge clk);
        op_type = 4'(o);
        a_rows = 3'(ar);
        a_cols = 3'(ac);
        b_rows = 3'(br);
        b_cols = 3'(bc);
        scalar = 8'(s);
        start_calc = 1'b1;
        lat = 0;
        got = 1'b0;
        while (lat < 3000 && !got) begin
            @(negedge clk);
            lat++;
            got = calc_done || error;
        end
        chk($sformatf("latency_op%0d", o), got ? lat : -1, exp_lat);
        if (ok && got) begin
            chk("res_rows", int'(res_rows), rr);
            chk("res_cols", int'(res_cols), rc);
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("hold_busy", int'(busy), 1);
        start_calc = 1'b0;
        cnt = 0;
        while (busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("back_to_idle", int'(busy), 0);
    endtask

    task automatic fill(input int mode);
        for (int x = 0; x < 32; x++) begin
            mem_a[x] = (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            mem_b[x] = (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        int o, ar, ac, br, bc, sel;
        fill(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mem_a[0] = 8'd1;  mem_a[1] = 8'd2;  mem_a[5] = 8'd3;  mem_a[6] = 8'd4;
        mem_b[0] = 8'd10; mem_b[1] = 8'd20; mem_b[5] = 8'd30; mem_b[6] = 8'd40;
        do_op(1, 2, 2, 2, 2, 0, 50);
        do_op(1, 2, 2, 2, 2, 0, 0);

        mem_a[0] = 8'd1; mem_a[1] = 8'd2;  mem_a[2] = 8'd3;
        mem_a[5] = 8'd4; mem_a[6] = 8'd5;  mem_a[7] = 8'd6;
        mem_b[0] = 8'd7; mem_b[1] = 8'd8;
        mem_b[5] = 8'd9; mem_b[6] = 8'd10;
        mem_b[10] = 8'd11; mem_b[11] = 8'd12;
        do_op(8, 2, 3, 3, 2, 0, 0);
        do_op(8, 2, 3, 2, 2, 0, 0);

        fill(1);
        do_op(8, 5, 5, 5, 5, 0, 0);
        fill(0);
        for (int x = 0; x < 32; x++) begin
            mem_a[x] = 8'(x);
            mem_b[x] = 8'(x + 100);
        end
        do_op(2, 3, 4, 3, 4, 0, 0);
        do_op(4, 2, 5, 0, 0, 0, 0);
        do_op(3, 5, 5, 0, 0, 255, 0);

        fill(1);
        @(negedge clk);
        op_type = OP_MUL;
        a_rows = 3'd5; a_cols = 3'd5; b_rows = 3'd5; b_cols = 3'd5;
        start_calc = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_mul_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_quiet("mid_reset");
        rst_n = 1'b1;
        start_calc = 1'b0;
        @(negedge clk);
        do_op(8, 5, 5, 5, 5, 0, 0);

        for (int t = 0; t < 40; t++) begin
            fill(($urandom_range(0, 5) == 0) ? 1 : 0);
            sel = $urandom_range(0, 8);
            o = (sel <= 4) ? ((sel == 4) ? 8 : sel + 1) : (sel == 5) ? 8 : 0;
            if (sel >= 6) begin
                o = $urandom_range(0, 15);
                if (o == 1 || o == 2 || o == 3 || o == 4 || o == 8) o = 0;
            end
            ar = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
            ac = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
            br = ($urandom_range(0, 3) != 0) ? ((o == 8) ? ac : ar) : $urandom_range(0, 7);
            bc = ($urandom_range(0, 3) != 0) ? ((o == 8) ? $urandom_range(1, 5) : ac) : $urandom_range(0, 7);
            do_op(o, ar, ac, br, bc, $urandom_range(0, 255), $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
